if_axis_fifo: RTL and testbench
===============================

// Module: if_axis_fifo
// PURPOSE
//  Memory-mapped AXI-Stream bridge for the SoC bus; successor of the single-register AXIS slave port.
//  Buffers inbound S_AXIS beats in an RX FIFO, read by the CPU, and outbound CPU writes in a TX FIFO drained on M_AXIS.
//  Adds depth/width parameters, a TX channel, occupancy counters, flush, a sticky error flag and an RX interrupt.
//  Decodes SOC_SEGMENT:SOC_CLASS on addr_i[31:16]; register select is addr_i[6:4].
// PARAMETERS
//  AXIS_DATA_WIDTH  8      stream data width, 1..32; bus data is zero-extended / truncated to it
//  FIFO_DEPTH_LOG2  4      log2 of entries per FIFO (depth 16); RX and TX identical
//  SOC_SEGMENT      32'he4 value matched against addr_i[31:24]
//  SOC_CLASS        32'ha9 value matched against addr_i[23:16]
// PORTS
//  axis_aclk_i      in   1     single clock, all logic posedge
//  axis_aresetn_i   in   1     reset, synchronous, active-low
//  addr_i           in   32    bus address
//  data_i           in   32    bus write data
//  data_w_i         in   1     1 = write access, 0 = read access
//  data_o           out  32    registered read data
//  data_access_o    out  1     combinational address-decode hit
//  irq_o            out  1     registered: irq_en & RX not empty
//  s_axis_tvalid_i  in   1     inbound stream valid
//  s_axis_tready_o  out  1     inbound stream ready
//  s_axis_tdata_i   in   AXIS_DATA_WIDTH inbound stream data
//  m_axis_tvalid_o  out  1     outbound stream valid
//  m_axis_tready_i  in   1     outbound stream ready
//  m_axis_tdata_o   out  AXIS_DATA_WIDTH outbound stream data
// BEHAVIOUR
//  Reset (axis_aresetn_i=0 at posedge): FIFOs empty, pointers/counts 0, data_o=0, irq_en=0, err=0,
//   irq_o=0, s_axis_tready_o=0 during reset, m_axis_tvalid_o=0; strobe-edge history cleared.
//  Strobe: acc = data_access & select match. A side effect fires only on the first cycle acc rises
//   (edge-detect vs previous cycle), so a CPU holding the address for N cycles pops/pushes once.
//  Register map (addr_i[6:4]):
//   001 CTRL/STATUS  R: {16'h0, rx_count[7:0] if fits else sat, 3'b0, err, tx_empty, tx_full, rx_full, rx_nempty}
//                    W: bit0 flush RX, bit1 flush TX, bit2 clear err, bit8 irq_en (held)
//   010 RX DATA      R: data_o <= zero-extended head, pop; if RX empty: data_o<=0, err<=1, no pop
//   011 TX DATA      W: push data_i[AXIS_DATA_WIDTH-1:0]; if TX full: drop, err<=1
//   100 COUNTS       R: {rx_count in [31:16], tx_count in [15:0]} (FIFO_DEPTH_LOG2+1 bits each)
//   other            R: data_o<=0; W: ignored
//  Read latency: data_o valid one cycle after the strobe edge; holds value until next decoded read.
//  RX: s_axis_tready_o = ~rx_full (registered-free, from count); beat stored when tvalid&tready.
//   Simultaneous stream push and CPU pop: both occur, count unchanged; pop on empty+push same cycle
//   counts as empty read (err set, beat stored).
//  TX: m_axis_tvalid_o = ~tx_empty; m_axis_tdata_o = head (combinational from storage); pop on
//   tvalid&tready. Push+pop same cycle on full TX: pop happens, push still rejected (full judged pre-edge).
//  Pointers wrap modulo 2**FIFO_DEPTH_LOG2; counts range 0..depth inclusive.
//  Flush: count/pointers -> 0 next cycle; same-cycle stream push into flushed FIFO is discarded;
//   flush has priority over push/pop. err clear wins over a same-cycle new error only if no new error.
//  Reset mid-transfer: in-flight beat lost; no tvalid/tready asserted in the reset cycle's output.
// TESTING
//  Send 3 S_AXIS beats 8'h11,8'h22,8'h33 -> STATUS rx_nempty=1, COUNTS rx=3; 3 RX reads return 0x11,0x22,0x33.
//  Hold RX DATA address 5 cycles -> exactly one pop, COUNTS rx decrements by 1.
//  Stream 17 beats with depth 16, no reads -> tready drops after 16th; 17th held until one read.
//  Read RX empty -> data_o=0, err=1; write CTRL 0x4 -> err=0.
//  Push 0xA5,0x5A to TX with m_axis_tready_i=0 -> tvalid=1, tdata=0xA5; raise tready -> 0xA5 then 0x5A, tvalid=0.
//  irq_en=1, one beat arrives -> irq_o=1 next cycle; flush RX (CTRL 0x101) -> rx_count=0, irq_o=0.

Source files
------------

// File: rtl/if_axis_fifo.sv
// Memory-mapped AXI-Stream bridge: inbound beats queue in an RX FIFO read by the CPU,
// CPU writes queue in a TX FIFO drained onto the outbound stream.
module if_axis_fifo #(
    parameter int unsigned AXIS_DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter logic [31:0] SOC_SEGMENT     = 32'he4,
    parameter logic [31:0] SOC_CLASS       = 32'ha9
) (
    input  logic                       axis_aclk_i,
    input  logic                       axis_aresetn_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                data_i,
    input  logic                       data_w_i,
    output logic [31:0]                data_o,
    output logic                       data_access_o,
    output logic                       irq_o,
    input  logic                       s_axis_tvalid_i,
    output logic                       s_axis_tready_o,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o
);

    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AXIS_DATA_WIDTH-1:0] r_rx_mem [DEPTH];
    logic [AXIS_DATA_WIDTH-1:0] r_tx_mem [DEPTH];
    logic [PW-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
    logic [CW-1:0] r_rx_count, r_tx_count;
    logic [31:0]   r_data;
    logic          r_err, r_irq_en, r_irq;
    logic          r_prev_acc, r_prev_we;
    logic [2:0]    r_prev_sel;

    logic [2:0]    w_sel;
    logic          w_stb, w_rd, w_wr;
    logic          w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic          w_rx_push, w_rx_pop, w_rx_flush, w_tx_push, w_tx_pop, w_tx_flush;
    logic          w_err_new, w_err_clr, w_err_n, w_irq_en_n;
    logic [CW-1:0] w_rx_count_n, w_tx_count_n;
    logic [7:0]    w_rx_cnt8;
    logic [31:0]   w_rdata;
    logic [AXIS_DATA_WIDTH-1:0] w_rx_head;
    logic          w_unused;

    assign data_access_o = (addr_i[31:24] == SOC_SEGMENT[7:0]) &&
                           (addr_i[23:16] == SOC_CLASS[7:0]);
    assign w_sel = addr_i[6:4];

    // Only the first cycle of an access (or a change of register/direction) acts
    assign w_stb = data_access_o &
                   ~(r_prev_acc & (r_prev_sel == w_sel) & (r_prev_we == data_w_i));
    assign w_rd  = w_stb & ~data_w_i;
    assign w_wr  = w_stb & data_w_i;

    assign w_rx_full  = (r_rx_count == FULL_CNT);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_tx_full  = (r_tx_count == FULL_CNT);
    assign w_tx_empty = (r_tx_count == '0);

    assign s_axis_tready_o = ~w_rx_full & axis_aresetn_i;
    assign m_axis_tvalid_o = ~w_tx_empty & axis_aresetn_i;
    assign m_axis_tdata_o  = r_tx_mem[r_tx_rptr];
    assign w_rx_head       = r_rx_mem[r_rx_rptr];

    assign w_rx_flush = w_wr & (w_sel == 3'd1) & data_i[0];
    assign w_tx_flush = w_wr & (w_sel == 3'd1) & data_i[1];
    assign w_err_clr  = w_wr & (w_sel == 3'd1) & data_i[2];
    assign w_irq_en_n = (w_wr & (w_sel == 3'd1)) ? data_i[8] : r_irq_en;

    assign w_rx_push = s_axis_tvalid_i & s_axis_tready_o & ~w_rx_flush;
    assign w_rx_pop  = w_rd & (w_sel == 3'd2) & ~w_rx_empty & ~w_rx_flush;
    assign w_tx_push = w_wr & (w_sel == 3'd3) & ~w_tx_full & ~w_tx_flush;
    assign w_tx_pop  = m_axis_tvalid_o & m_axis_tready_i & ~w_tx_flush;

    assign w_err_new = (w_rd & (w_sel == 3'd2) & w_rx_empty) |
                       (w_wr & (w_sel == 3'd3) & w_tx_full);
    assign w_err_n   = w_err_new ? 1'b1 : (w_err_clr ? 1'b0 : r_err);

    assign w_rx_count_n = w_rx_flush ? '0 : r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
    assign w_tx_count_n = w_tx_flush ? '0 : r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);

    if (CW <= 8) begin : g_cnt_fit
        assign w_rx_cnt8 = 8'(r_rx_count);
    end else begin : g_cnt_sat
        assign w_rx_cnt8 = (r_rx_count > CW'(255)) ? 8'hff : r_rx_count[7:0];
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_sel)
            3'd1:    w_rdata = {16'h0, w_rx_cnt8, 3'b0, r_err, w_tx_empty, w_tx_full,
                                w_rx_full, ~w_rx_empty};
            3'd2:    w_rdata = w_rx_empty ? 32'h0 : 32'(w_rx_head);
            3'd4:    w_rdata = {16'(r_rx_count), 16'(r_tx_count)};
            default: w_rdata = 32'h0;
        endcase
    end

    // Storage needs no reset: pointers and counts define what is valid
    always_ff @(posedge axis_aclk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= s_axis_tdata_i;
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= data_i[AXIS_DATA_WIDTH-1:0];
    end

    always_ff @(posedge axis_aclk_i) begin
        if (!axis_aresetn_i) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_rx_count <= '0;
            r_tx_count <= '0;
            r_data     <= 32'h0;
            r_err      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
            r_prev_acc <= 1'b0;
            r_prev_we  <= 1'b0;
            r_prev_sel <= 3'd0;
        end else begin
            r_prev_acc <= data_access_o;
            r_prev_we  <= data_w_i;
            r_prev_sel <= w_sel;
            if (w_rx_flush) begin
                r_rx_wptr <= '0;
                r_rx_rptr <= '0;
            end else begin
                if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
                if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            if (w_tx_flush) begin
                r_tx_wptr <= '0;
                r_tx_rptr <= '0;
            end else begin
                if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
                if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            r_rx_count <= w_rx_count_n;
            r_tx_count <= w_tx_count_n;
            if (w_rd) r_data <= w_rdata;
            r_err    <= w_err_n;
            r_irq_en <= w_irq_en_n;
            r_irq    <= w_irq_en_n & (w_rx_count_n != '0);
        end
    end

    assign data_o = r_data;
    assign irq_o  = r_irq;

    assign w_unused = &{1'b0, addr_i[15:7], addr_i[3:0], data_i};

endmodule

// File: tb/tb_if_axis_fifo.sv
// Self-checking bench for if_axis_fifo: directed table, corner sequences, and a
// randomized run against a queue-based model.
module tb_if_axis_fifo;

    localparam logic [31:0] BASE = 32'he4a9_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        we = 1'b0;
    logic [31:0] data_o;
    logic        data_access;
    logic        irq;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tdata = 8'h0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [7:0]  m_tdata;

    int checks = 0;
    int failures = 0;

    if_axis_fifo dut (
        .axis_aclk_i    (clk),
        .axis_aresetn_i (rstn),
        .addr_i         (addr),
        .data_i         (wdata),
        .data_w_i       (we),
        .data_o         (data_o),
        .data_access_o  (data_access),
        .irq_o          (irq),
        .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready),
        .s_axis_tdata_i (s_tdata),
        .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready),
        .m_axis_tdata_o (m_tdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One strobed access followed by an idle cycle so the next access is a new edge
    task automatic bus(input logic w, input logic [2:0] sel, input logic [31:0] d);
        addr  = BASE | {25'h0, sel, 4'h0};
        we    = w;
        wdata = d;
        tick;
        addr  = 32'h0;
        we    = 1'b0;
        tick;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  sel;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [14];

    // Reference model state
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic        m_err, m_irq_en, m_irq;
    logic [31:0] m_data;

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(rx_q.size()), 3'b0, m_err, tx_q.size() == 0, tx_q.size() == 16,
                rx_q.size() == 16, rx_q.size() != 0};
    endfunction

    initial begin
        int acc;
        // Reset: outputs quiet even with an inbound beat offered
        s_tvalid = 1'b1;
        #1;
        chk("rst_tready", 32'(s_tready), 0);
        tick;
        tick;
        chk("rst_data_o", data_o, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        s_tvalid = 1'b0;
        rstn = 1'b1;
        tick;
        chk("decode_idle", 32'(data_access), 0);

        // Three inbound beats
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 8'(8'h11 * (i + 1));
            tick;
        end
        s_tvalid = 1'b0;
        chk("irq_disabled", 32'(irq), 0);

        tbl[0]  = '{1'b0, 3'd1, 32'h0,   32'h0000_0309};
        tbl[1]  = '{1'b0, 3'd4, 32'h0,   32'h0003_0000};
        tbl[2]  = '{1'b0, 3'd2, 32'h0,   32'h11};
        tbl[3]  = '{1'b0, 3'd2, 32'h0,   32'h22};
        tbl[4]  = '{1'b0, 3'd2, 32'h0,   32'h33};
        tbl[5]  = '{1'b0, 3'd2, 32'h0,   32'h0};
        tbl[6]  = '{1'b0, 3'd1, 32'h0,   32'h18};
        tbl[7]  = '{1'b1, 3'd1, 32'h4,   32'h18};
        tbl[8]  = '{1'b0, 3'd1, 32'h0,   32'h08};
        tbl[9]  = '{1'b1, 3'd3, 32'ha5,  32'h08};
        tbl[10] = '{1'b1, 3'd3, 32'h15a, 32'h08};
        tbl[11] = '{1'b0, 3'd4, 32'h0,   32'h0000_0002};
        tbl[12] = '{1'b0, 3'd1, 32'h0,   32'h0};
        tbl[13] = '{1'b0, 3'd6, 32'h0,   32'h0};
        for (int i = 0; i < 14; i++) begin
            bus(tbl[i].w, tbl[i].sel, tbl[i].d);
            chk($sformatf("tbl%0d", i), data_o, tbl[i].exp);
        end

        // TX drain
        chk("tx_tvalid0", 32'(m_tvalid), 1);
        chk("tx_tdata0", 32'(m_tdata), 32'ha5);
        m_tready = 1'b1;
        tick;
        chk("tx_tvalid1", 32'(m_tvalid), 1);
        chk("tx_tdata1", 32'(m_tdata), 32'h5a);
        tick;
        chk("tx_tvalid2", 32'(m_tvalid), 0);
        m_tready = 1'b0;

        // Address held for 5 cycles pops exactly once
        s_tvalid = 1'b1;
        s_tdata = 8'h61;
        tick;
        s_tdata = 8'h62;
        tick;
        s_tvalid = 1'b0;
        addr = BASE | 32'h20;
        repeat (5) tick;
        addr = 32'h0;
        tick;
        chk("hold_data", data_o, 32'h61);
        bus(1'b0, 3'd4, 0);
        chk("hold_counts", data_o, 32'h0001_0000);
        bus(1'b0, 3'd2, 0);
        chk("hold_rd2", data_o, 32'h62);

        // 17 beats into a 16-deep RX
        acc = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 40 && acc < 16; c++) begin
            s_tdata = 8'(acc);
            if (s_tready) acc++;
            tick;
        end
        chk("fill_accepted", acc, 16);
        s_tdata = 8'd16;
        chk("fill_tready_low", 32'(s_tready), 0);
        repeat (3) tick;
        chk("fill_still_low", 32'(s_tready), 0);
        chk("fill_full_status", data_o & 32'h0, 32'h0);
        bus(1'b0, 3'd2, 0);
        s_tvalid = 1'b0;
        chk("fill_rd0", data_o, 32'h0);
        bus(1'b0, 3'd4, 0);
        chk("fill_counts", data_o, 32'h0010_0000);
        for (int i = 1; i <= 16; i++) begin
            bus(1'b0, 3'd2, 0);
            chk($sformatf("fill_rd%0d", i), data_o, 32'(i));
        end

        // Interrupt and RX flush
        bus(1'b1, 3'd1, 32'h100);
        s_tvalid = 1'b1;
        s_tdata = 8'h42;
        tick;
        s_tvalid = 1'b0;
        chk("irq_set", 32'(irq), 1);
        bus(1'b1, 3'd1, 32'h101);
        chk("irq_flush", 32'(irq), 0);
        bus(1'b0, 3'd4, 0);
        chk("flush_counts", data_o, 32'h0);

        // TX overflow then flush TX and clear err together
        for (int i = 0; i < 17; i++) bus(1'b1, 3'd3, 32'(8'h80 + i));
        bus(1'b0, 3'd4, 0);
        chk("txfull_counts", data_o, 32'h0000_0010);
        bus(1'b0, 3'd1, 0);
        chk("txfull_status", data_o, 32'h14);
        chk("txfull_head", 32'(m_tdata), 32'h80);
        bus(1'b1, 3'd1, 32'h6);
        bus(1'b0, 3'd1, 0);
        chk("txflush_status", data_o, 32'h08);

        // Reset mid-transfer
        bus(1'b1, 3'd3, 32'h77);
        s_tvalid = 1'b1;
        rstn = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(m_tvalid), 0);
        chk("midrst_tready", 32'(s_tready), 0);
        tick;
        tick;
        chk("midrst_data_o", data_o, 0);
        s_tvalid = 1'b0;
        rstn = 1'b1;
        #1;
        chk("midrst_tx_empty", 32'(m_tvalid), 0);

        // Randomized run against the queue model
        rx_q.delete();
        tx_q.delete();
        m_err = 1'b0;
        m_irq_en = 1'b0;
        m_irq = 1'b0;
        m_data = 32'h0;
        begin
            logic prev_acc;
            prev_acc = 1'b0;
            for (int cyc = 0; cyc < 800; cyc++) begin
                int r;
                logic a, w, rd, wr, rxflush, txflush, clr, newerr, push_tx, push_rx, pop_tx;
                logic [2:0]  sel;
                logic [31:0] d;
                logic [7:0]  sd;
                chk("rnd_tready", 32'(s_tready), 32'(rx_q.size() < 16));
                chk("rnd_tvalid", 32'(m_tvalid), 32'(tx_q.size() > 0));
                if (tx_q.size() > 0) chk("rnd_tdata", 32'(m_tdata), 32'(tx_q[0]));
                chk("rnd_data_o", data_o, m_data);
                chk("rnd_irq", 32'(irq), 32'(m_irq));

                a = 1'b0; w = 1'b0; sel = 3'd0; d = 32'h0;
                if (!prev_acc) begin
                    r = $urandom_range(0, 15);
                    a = (r >= 5);
                    if (r <= 8)       begin w = 1'b0; sel = 3'd2; end
                    else if (r <= 11) begin w = 1'b1; sel = 3'd3; d = $urandom; end
                    else if (r == 12) begin w = 1'b0; sel = 3'd4; end
                    else if (r == 13) begin w = 1'b0; sel = 3'd1; end
                    else if (r == 14) begin
                        w = 1'b1; sel = 3'd1;
                        d = {23'h0, 1'($urandom), 5'h0, 1'($urandom),
                             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
                    end else begin w = 1'($urandom); sel = 3'($urandom); d = $urandom; end
                end
                prev_acc = a;
                sd = 8'($urandom);
                addr = a ? (BASE | {25'h0, sel, 4'h0}) : 32'h0;
                we = w;
                wdata = d;
                s_tvalid = ($urandom_range(0, 9) < 6);
                s_tdata = sd;
                m_tready = 1'($urandom);

                rd = a & ~w;
                wr = a & w;
                rxflush = wr && sel == 3'd1 && d[0];
                txflush = wr && sel == 3'd1 && d[1];
                clr = wr && sel == 3'd1 && d[2];
                push_rx = s_tvalid && rx_q.size() < 16 && !rxflush;
                pop_tx = tx_q.size() > 0 && m_tready && !txflush;
                push_tx = 1'b0;
                newerr = 1'b0;
                if (rd) begin
                    case (sel)
                        3'd1: m_data = m_status();
                        3'd2: if (rx_q.size() > 0) m_data = 32'(rx_q.pop_front());
                              else begin m_data = 32'h0; newerr = 1'b1; end
                        3'd4: m_data = {16'(rx_q.size()), 16'(tx_q.size())};
                        default: m_data = 32'h0;
                    endcase
                end
                if (wr && sel == 3'd3) begin
                    if (tx_q.size() == 16) newerr = 1'b1;
                    else push_tx = 1'b1;
                end
                if (pop_tx) void'(tx_q.pop_front());
                if (push_tx) tx_q.push_back(d[7:0]);
                if (push_rx) rx_q.push_back(sd);
                if (rxflush) rx_q.delete();
                if (txflush) tx_q.delete();
                if (newerr) m_err = 1'b1;
                else if (clr) m_err = 1'b0;
                if (wr && sel == 3'd1) m_irq_en = d[8];
                m_irq = m_irq_en && rx_q.size() > 0;
                tick;
            end
        end
        addr = 32'h0;
        s_tvalid = 1'b0;
        bus(1'b0, 3'd1, 0);
        chk("rnd_final_status", data_o, m_status());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
